fixed_point_div: RTL

FIXED_POINT_DIV -- requirements
Module: fixed_point_div

---
 rtl/fixed_point_div.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider: one restoring-division step per cycle on
// magnitudes, then sign, saturation and divide-by-zero handling on the way out.
module fixed_point_div #(
  parameter int unsigned INTEGER_PART_WIDTH    = 2,
  parameter int unsigned FRACTIONAL_PART_WIDTH = 1,
  localparam int unsigned NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUMBER_WIDTH-1:0] a,
  input  logic [NUMBER_WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [NUMBER_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    div_by_zero
);

  localparam int unsigned N     = NUMBER_WIDTH;
  localparam int unsigned FW    = FRACTIONAL_PART_WIDTH;
  localparam int unsigned Q     = N + FW;
  localparam int unsigned CNT_W = $clog2(Q + 1);

  localparam logic [N-1:0] MAX_POS     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG     = {1'b1, {(N-1){1'b0}}};
  localparam logic [Q-1:0] MAX_POS_MAG = Q'(MAX_POS);
  localparam logic [Q-1:0] MIN_NEG_MAG = Q'(MIN_NEG);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t           state;
  logic             neg_q;
  logic             a_neg_q;
  logic             b_zero_q;
  logic [N-1:0]     divisor_q;
  logic [N-1:0]     rem_q;
  logic [Q-1:0]     dq_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;
  logic [N:0]   rem_shift;
  logic         rem_ge;
  logic [N-1:0] rem_next;
  logic [N-1:0] fin_result;
  logic         fin_overflow;

  // Operand magnitudes; the most negative value maps onto 2^(N-1) unsigned.
  always_comb begin
    a_abs = a[N-1] ? N'(-a) : a;
    b_abs = b[N-1] ? N'(-b) : b;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, dq_q[Q-1]};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    rem_next  = rem_ge ? N'(rem_shift - {1'b0, divisor_q}) : rem_shift[N-1:0];
  end

  // Signed, saturated result from the final quotient magnitude held in dq_q.
  always_comb begin
    fin_result   = '0;
    fin_overflow = 1'b0;
    if (b_zero_q) begin
      fin_result = a_neg_q ? MIN_NEG : MAX_POS;
    end else if (neg_q) begin
      if (dq_q > MIN_NEG_MAG) begin
        fin_result   = MIN_NEG;
        fin_overflow = 1'b1;
      end else begin
        fin_result = N'(-dq_q);
      end
    end else begin
      if (dq_q > MAX_POS_MAG) begin
        fin_result   = MAX_POS;
        fin_overflow = 1'b1;
      end else begin
        fin_result = dq_q[N-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      divisor_q   <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      cnt_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            neg_q     <= a[N-1] ^ b[N-1];
            a_neg_q   <= a[N-1];
            b_zero_q  <= (b == '0);
            divisor_q <= b_abs;
            dq_q      <= {a_abs, {FW{1'b0}}};
            rem_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state     <= DIVIDE;
          end
        end
        DIVIDE: begin
          dq_q  <= {dq_q[Q-2:0], rem_ge};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(Q - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          result      <= fin_result;
          overflow    <= fin_overflow;
          div_by_zero <= b_zero_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
